// File: rtl/vector_list_builder.sv
// vector_list_builder
//   Producer side of the vector display list. Converts a command stream
//   (BEGIN, POINT, END_SHAPE, END_LIST) into the byte layout the vector
//   renderer reads from vector RAM:
//     [points-1][attr][x0][y0]...[xN][yN] ... [0]
//   Each shape's length byte is written last, and a new terminator is
//   written before it, so the list in RAM is always terminated.
//
// Ports
//   clk, reset          system clock, async active-high reset
//   cmd_valid/ready     command handshake (accept = valid && ready)
//   cmd_op, cmd_data    0=BEGIN(attr), 1=POINT(y,x), 2=END_SHAPE, 3=END_LIST
//   origin_x/y          offset added to POINT coordinates at accept
//   err_clr             clears the sticky error bits
//   ram_addr/data/wr    vector RAM write port (registered)
//   list_done           one-cycle pulse when END_LIST writes its terminator
//   shape_count         shapes committed since last END_LIST (saturating)
//   error               sticky: [0] sequence, [1] too many points, [2] overflow
module vector_list_builder #(
  parameter int VECTOR_RAM_WIDTH  = 9,
  parameter int VECTOR_POINTS_MAX = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [1:0]                  cmd_op,
  input  logic [15:0]                 cmd_data,
  input  logic [7:0]                  origin_x,
  input  logic [7:0]                  origin_y,
  input  logic                        err_clr,
  output logic [VECTOR_RAM_WIDTH-1:0] ram_addr,
  output logic [7:0]                  ram_data,
  output logic                        ram_wr,
  output logic                        list_done,
  output logic [7:0]                  shape_count,
  output logic [2:0]                  error
);

  localparam int AW    = VECTOR_RAM_WIDTH;
  localparam int DEPTH = 2 ** AW;
  // Wide enough that hdr + 4 + 2*npts never wraps in the overflow checks.
  localparam int EW    = AW + 6;
  localparam int NW    = $clog2(VECTOR_POINTS_MAX + 1);
  localparam logic [EW-1:0] LIMIT = EW'(DEPTH - 1);

  localparam logic [1:0] OP_BEGIN     = 2'd0;
  localparam logic [1:0] OP_POINT     = 2'd1;
  localparam logic [1:0] OP_END_SHAPE = 2'd2;

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_WR2} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wp_q, wp_d;
  logic [AW-1:0]   hdr_q, hdr_d;
  logic [NW-1:0]   npts_q, npts_d;
  logic            in_shape_q, in_shape_d;
  logic [AW-1:0]   pend_addr_q, pend_addr_d;
  logic [7:0]      pend_data_q, pend_data_d;
  logic [AW-1:0]   ram_addr_q, ram_addr_d;
  logic [7:0]      ram_data_q, ram_data_d;
  logic            ram_wr_q, ram_wr_d;
  logic            cmd_ready_q, cmd_ready_d;
  logic            list_done_q, list_done_d;
  logic [7:0]      shape_count_q, shape_count_d;
  logic [2:0]      error_q, error_d;
  logic [2:0]      err_set;

  logic [EW-1:0]   wp_e, pt_addr_e;
  logic [7:0]      pt_x, pt_y;

  assign wp_e      = EW'(wp_q);
  // Address of the next point's x byte; also where END_SHAPE puts the terminator.
  assign pt_addr_e = EW'(hdr_q) + EW'(2) + (EW'(npts_q) << 1);
  assign pt_x      = cmd_data[7:0] + origin_x;
  assign pt_y      = cmd_data[15:8] + origin_y;

  always_comb begin
    state_d       = state_q;
    wp_d          = wp_q;
    hdr_d         = hdr_q;
    npts_d        = npts_q;
    in_shape_d    = in_shape_q;
    pend_addr_d   = pend_addr_q;
    pend_data_d   = pend_data_q;
    ram_addr_d    = ram_addr_q;
    ram_data_d    = ram_data_q;
    ram_wr_d      = 1'b0;
    list_done_d   = 1'b0;
    shape_count_d = shape_count_q;
    err_set       = 3'b000;

    case (state_q)
      ST_INIT: begin
        ram_wr_d   = 1'b1;
        ram_addr_d = '0;
        ram_data_d = 8'h00;
        state_d    = ST_IDLE;
      end
      ST_WR2: begin
        ram_wr_d   = 1'b1;
        ram_addr_d = pend_addr_q;
        ram_data_d = pend_data_q;
        state_d    = ST_IDLE;
      end
      default: begin
        if (cmd_valid && cmd_ready_q) begin
          case (cmd_op)
            OP_BEGIN: begin
              // An open shape is dropped; its header is still 0 and wp == hdr.
              if (in_shape_q) err_set[0] = 1'b1;
              in_shape_d = 1'b0;
              if (wp_e + EW'(2) > LIMIT) begin
                err_set[2] = 1'b1;
              end else begin
                hdr_d       = wp_q;
                npts_d      = '0;
                in_shape_d  = 1'b1;
                ram_wr_d    = 1'b1;
                ram_addr_d  = wp_q;
                ram_data_d  = 8'h00;
                pend_addr_d = wp_q + AW'(1);
                pend_data_d = cmd_data[7:0];
                state_d     = ST_WR2;
              end
            end
            OP_POINT: begin
              if (!in_shape_q) begin
                err_set[0] = 1'b1;
              end else if (npts_q == NW'(VECTOR_POINTS_MAX)) begin
                err_set[1] = 1'b1;
              end else if (pt_addr_e + EW'(2) > LIMIT) begin
                // No room for the terminator after this point.
                in_shape_d = 1'b0;
                wp_d       = hdr_q;
                err_set[2] = 1'b1;
              end else begin
                ram_wr_d    = 1'b1;
                ram_addr_d  = AW'(pt_addr_e);
                ram_data_d  = pt_x;
                pend_addr_d = AW'(pt_addr_e) + AW'(1);
                pend_data_d = pt_y;
                npts_d      = npts_q + NW'(1);
                state_d     = ST_WR2;
              end
            end
            OP_END_SHAPE: begin
              if (!in_shape_q) begin
                err_set[0] = 1'b1;
              end else if (npts_q < NW'(2)) begin
                in_shape_d = 1'b0;
                wp_d       = hdr_q;
                err_set[0] = 1'b1;
              end else begin
                // Terminator first, then the length byte commits the shape.
                ram_wr_d    = 1'b1;
                ram_addr_d  = AW'(pt_addr_e);
                ram_data_d  = 8'h00;
                pend_addr_d = hdr_q;
                pend_data_d = 8'(npts_q) - 8'd1;
                wp_d        = AW'(pt_addr_e);
                in_shape_d  = 1'b0;
                if (shape_count_q != 8'hFF) shape_count_d = shape_count_q + 8'd1;
                state_d     = ST_WR2;
              end
            end
            default: begin
              if (in_shape_q) err_set[0] = 1'b1;
              in_shape_d    = 1'b0;
              ram_wr_d      = 1'b1;
              ram_addr_d    = wp_q;
              ram_data_d    = 8'h00;
              list_done_d   = 1'b1;
              wp_d          = '0;
              shape_count_d = 8'h00;
            end
          endcase
        end
      end
    endcase

    // The cycle carrying the INIT write keeps cmd_ready low.
    cmd_ready_d = (state_d == ST_IDLE) && (state_q != ST_INIT);
    error_d     = (err_clr ? 3'b000 : error_q) | err_set;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_INIT;
      wp_q          <= '0;
      hdr_q         <= '0;
      npts_q        <= '0;
      in_shape_q    <= 1'b0;
      pend_addr_q   <= '0;
      pend_data_q   <= 8'h00;
      ram_addr_q    <= '0;
      ram_data_q    <= 8'h00;
      ram_wr_q      <= 1'b0;
      cmd_ready_q   <= 1'b0;
      list_done_q   <= 1'b0;
      shape_count_q <= 8'h00;
      error_q       <= 3'b000;
    end else begin
      state_q       <= state_d;
      wp_q          <= wp_d;
      hdr_q         <= hdr_d;
      npts_q        <= npts_d;
      in_shape_q    <= in_shape_d;
      pend_addr_q   <= pend_addr_d;
      pend_data_q   <= pend_data_d;
      ram_addr_q    <= ram_addr_d;
      ram_data_q    <= ram_data_d;
      ram_wr_q      <= ram_wr_d;
      cmd_ready_q   <= cmd_ready_d;
      list_done_q   <= list_done_d;
      shape_count_q <= shape_count_d;
      error_q       <= error_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign ram_addr    = ram_addr_q;
  assign ram_data    = ram_data_q;
  assign ram_wr      = ram_wr_q;
  assign list_done   = list_done_q;
  assign shape_count = shape_count_q;
  assign error       = error_q;

endmodule
